// File: rtl/rocket_pkg.sv
// Shared types for the stage burn sequencer: FSM state encoding and
// the saturating mass subtraction used by every mass update.
package rocket_pkg;

    localparam int STAGE_W = 2;
    localparam int SUB_W   = 64;

    typedef enum logic [2:0] {
        IDLE,
        BURN,
        DV_WAIT,
        SEP,
        COAST,
        DONE
    } state_e;

    typedef struct packed {
        logic [SUB_W-1:0] diff;
        logic             borrow;
    } sub_t;

    function automatic sub_t sat_sub(
        input logic [SUB_W-1:0] a,
        input logic [SUB_W-1:0] b
    );
        sub_t r;
        r.borrow = (b > a);
        r.diff   = r.borrow ? '0 : a - b;
        return r;
    endfunction

endpackage

// File: rtl/stage_cfg_regfile.sv
// Per-stage {burn, flow, dry} configuration store, one write port and
// one asynchronous read port; indices at or above NUM_STAGES are inert.
module stage_cfg_regfile
    import rocket_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int MASS_W     = 32,
    parameter int TICK_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [STAGE_W-1:0] wr_idx_i,
    input  logic [TICK_W-1:0] wr_burn_i,
    input  logic [MASS_W-1:0] wr_flow_i,
    input  logic [MASS_W-1:0] wr_dry_i,
    input  logic [STAGE_W-1:0] rd_idx_i,
    output logic [TICK_W-1:0] rd_burn_o,
    output logic [MASS_W-1:0] rd_flow_o,
    output logic [MASS_W-1:0] rd_dry_o
);

    localparam int DEPTH = 1 << STAGE_W;
    localparam logic [STAGE_W:0] LIMIT = (STAGE_W + 1)'(NUM_STAGES);

    logic [TICK_W-1:0] burn_q [DEPTH];
    logic [MASS_W-1:0] flow_q [DEPTH];
    logic [MASS_W-1:0] dry_q  [DEPTH];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = ({1'b0, wr_idx_i} < LIMIT);
    assign rd_ok = ({1'b0, rd_idx_i} < LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                burn_q[i] <= '0;
                flow_q[i] <= '0;
                dry_q[i]  <= '0;
            end
        end else if (we_i && wr_ok) begin
            burn_q[wr_idx_i] <= wr_burn_i;
            flow_q[wr_idx_i] <= wr_flow_i;
            dry_q[wr_idx_i]  <= wr_dry_i;
        end
    end

    assign rd_burn_o = rd_ok ? burn_q[rd_idx_i] : '0;
    assign rd_flow_o = rd_ok ? flow_q[rd_idx_i] : '0;
    assign rd_dry_o  = rd_ok ? dry_q[rd_idx_i]  : '0;

endmodule

// File: rtl/stage_burn_sequencer.sv
// Multi-stage ascent sequencer feeding (m_start, m_end) pairs to the dv unit.
// Define LES_JETTISON_EN to add the launch-escape-system jettison and les_pulse.
module stage_burn_sequencer
    import rocket_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int MASS_W      = 32,
    parameter int TICK_W      = 16,
    parameter int COAST_TICKS = 4
`ifdef LES_JETTISON_EN
    ,
    parameter int LES_STAGE   = 1,
    parameter int LES_TICK    = 30,
    parameter int LES_MASS    = 3629
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [STAGE_W-1:0] cfg_stage,
    input  logic [TICK_W-1:0]  cfg_burn,
    input  logic [MASS_W-1:0]  cfg_flow,
    input  logic [MASS_W-1:0]  cfg_dry,
    input  logic               launch,
    input  logic [MASS_W-1:0]  m0,
    input  logic               abort,
    output logic [MASS_W-1:0]  mass,
    output logic [STAGE_W-1:0] stage,
    output logic               burning,
    output logic               sep_pulse,
    output logic               dv_req,
    output logic [MASS_W-1:0]  dv_m_start,
    output logic [MASS_W-1:0]  dv_m_end,
    input  logic               dv_ack,
    output logic               done,
`ifdef LES_JETTISON_EN
    output logic               les_pulse,
`endif
    output logic               fault
);

    localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);

    state_e             state_q, state_d;
    logic [MASS_W-1:0]  mass_q, mass_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [TICK_W-1:0]  cnt_q, cnt_d;
    logic               dv_req_q, dv_req_d;
    logic [MASS_W-1:0]  m_start_q, m_start_d;
    logic [MASS_W-1:0]  m_end_q, m_end_d;
    logic               fault_q, fault_d;

    logic [STAGE_W-1:0] rd_idx;
    logic [TICK_W-1:0]  rd_burn;
    logic [MASS_W-1:0]  rd_flow;
    logic [MASS_W-1:0]  rd_dry;
    logic               cfg_wr;

    logic [SUB_W-1:0]   sub_amt;
    sub_t               sub_r;
    logic [MASS_W-1:0]  sub_mass;
    logic               les_hit;
    logic               ign;
    logic [MASS_W-1:0]  ign_mass;

    assign cfg_wr = cfg_we && (state_q == IDLE);

    stage_cfg_regfile #(
        .NUM_STAGES (NUM_STAGES),
        .MASS_W     (MASS_W),
        .TICK_W     (TICK_W)
    ) u_cfg (
        .clk       (clk),
        .reset     (reset),
        .we_i      (cfg_wr),
        .wr_idx_i  (cfg_stage),
        .wr_burn_i (cfg_burn),
        .wr_flow_i (cfg_flow),
        .wr_dry_i  (cfg_dry),
        .rd_idx_i  (rd_idx),
        .rd_burn_o (rd_burn),
        .rd_flow_o (rd_flow),
        .rd_dry_o  (rd_dry)
    );

    // Read port points at the stage about to ignite when one may ignite.
    always_comb begin
        rd_idx = stage_q;
        if (state_q == IDLE || state_q == DONE) begin
            rd_idx = '0;
        end else if (state_q == COAST) begin
            rd_idx = stage_q + STAGE_W'(1);
        end
    end

`ifdef LES_JETTISON_EN
    assign les_hit = (state_q == BURN)
                  && (stage_q == STAGE_W'(LES_STAGE))
                  && (cnt_q == TICK_W'(LES_TICK));
    assign les_pulse = les_hit;
`else
    assign les_hit = 1'b0;
`endif

    always_comb begin
        sub_amt = '0;
        if (state_q == BURN) begin
            sub_amt = SUB_W'(rd_flow);
`ifdef LES_JETTISON_EN
            if (les_hit) begin
                sub_amt = SUB_W'(rd_flow) + SUB_W'(LES_MASS);
            end
`endif
        end else if (state_q == SEP) begin
            sub_amt = SUB_W'(rd_dry);
        end
    end

    assign sub_r    = sat_sub(SUB_W'(mass_q), sub_amt);
    assign sub_mass = MASS_W'(sub_r.diff);

    always_comb begin
        state_d   = state_q;
        mass_d    = mass_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        dv_req_d  = dv_req_q;
        m_start_d = m_start_q;
        m_end_d   = m_end_q;
        fault_d   = fault_q;
        ign       = 1'b0;
        ign_mass  = mass_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    ign      = 1'b1;
                    ign_mass = m0;
                end
            end
            BURN: begin
                mass_d  = sub_mass;
                fault_d = fault_q | sub_r.borrow;
                cnt_d   = cnt_q + TICK_W'(1);
                if (cnt_q == rd_burn - TICK_W'(1)) begin
                    state_d  = DV_WAIT;
                    m_end_d  = sub_mass;
                    dv_req_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            DV_WAIT: begin
                if (dv_ack) begin
                    state_d  = SEP;
                    dv_req_d = 1'b0;
                end
            end
            SEP: begin
                mass_d  = sub_mass;
                fault_d = fault_q | sub_r.borrow;
                state_d = COAST;
                cnt_d   = '0;
            end
            COAST: begin
                cnt_d = cnt_q + TICK_W'(1);
                if (cnt_q == TICK_W'(COAST_TICKS - 1)) begin
                    cnt_d = '0;
                    if (stage_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        ign = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A zero-length burn goes straight to the handshake.
        if (ign) begin
            stage_d   = rd_idx;
            m_start_d = ign_mass;
            mass_d    = ign_mass;
            cnt_d     = '0;
            if (rd_burn == '0) begin
                state_d  = DV_WAIT;
                m_end_d  = ign_mass;
                dv_req_d = 1'b1;
            end else begin
                state_d = BURN;
            end
        end

        if (abort) begin
            state_d  = IDLE;
            mass_d   = '0;
            stage_d  = '0;
            dv_req_d = 1'b0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mass_q    <= '0;
            stage_q   <= '0;
            cnt_q     <= '0;
            dv_req_q  <= 1'b0;
            m_start_q <= '0;
            m_end_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mass_q    <= mass_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            dv_req_q  <= dv_req_d;
            m_start_q <= m_start_d;
            m_end_q   <= m_end_d;
            fault_q   <= fault_d;
        end
    end

    assign mass       = mass_q;
    assign stage      = stage_q;
    assign burning    = (state_q == BURN);
    assign sep_pulse  = (state_q == SEP);
    assign dv_req     = dv_req_q;
    assign dv_m_start = m_start_q;
    assign dv_m_end   = m_end_q;
    assign done       = (state_q == DONE);
    assign fault      = fault_q;

endmodule

// File: tb/tb_stage_burn_sequencer.sv
// Directed bench for stage_burn_sequencer: a 3-stage instance plus a
// 1-stage instance sharing stimulus; expected masses derived in-bench.
module tb_stage_burn_sequencer;

    localparam int COAST = 4;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_stage;
    logic [15:0] cfg_burn;
    logic [31:0] cfg_flow;
    logic [31:0] cfg_dry;
    logic        launch;
    logic [31:0] m0;
    logic        abort;
    logic        dv_ack;

    logic [31:0] mass, dv_m_start, dv_m_end;
    logic [1:0]  stage;
    logic        burning, sep_pulse, dv_req, done, fault;

    logic [31:0] d1_mass, d1_m_start, d1_m_end;
    logic [1:0]  d1_stage;
    logic        d1_burning, d1_sep, d1_req, d1_done, d1_fault;

`ifdef LES_JETTISON_EN
    logic        les_pulse;
    logic        d1_les;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    stage_burn_sequencer #(.NUM_STAGES(3), .COAST_TICKS(COAST)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_stage  (cfg_stage),
        .cfg_burn   (cfg_burn),
        .cfg_flow   (cfg_flow),
        .cfg_dry    (cfg_dry),
        .launch     (launch),
        .m0         (m0),
        .abort      (abort),
        .mass       (mass),
        .stage      (stage),
        .burning    (burning),
        .sep_pulse  (sep_pulse),
        .dv_req     (dv_req),
        .dv_m_start (dv_m_start),
        .dv_m_end   (dv_m_end),
        .dv_ack     (dv_ack),
        .done       (done),
`ifdef LES_JETTISON_EN
        .les_pulse  (les_pulse),
`endif
        .fault      (fault)
    );

    stage_burn_sequencer #(.NUM_STAGES(1), .COAST_TICKS(COAST)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_stage  (cfg_stage),
        .cfg_burn   (cfg_burn),
        .cfg_flow   (cfg_flow),
        .cfg_dry    (cfg_dry),
        .launch     (launch),
        .m0         (m0),
        .abort      (abort),
        .mass       (d1_mass),
        .stage      (d1_stage),
        .burning    (d1_burning),
        .sep_pulse  (d1_sep),
        .dv_req     (d1_req),
        .dv_m_start (d1_m_start),
        .dv_m_end   (d1_m_end),
        .dv_ack     (dv_ack),
        .done       (d1_done),
`ifdef LES_JETTISON_EN
        .les_pulse  (d1_les),
`endif
        .fault      (d1_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic cfg(input int s, input int burn, input longint flow,
                       input longint dry);
        cfg_we    = 1'b1;
        cfg_stage = 2'(s);
        cfg_burn  = 16'(burn);
        cfg_flow  = 32'(flow);
        cfg_dry   = 32'(dry);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic fire(input longint m);
        m0     = 32'(m);
        launch = 1'b1;
        tick();
        launch = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 2000 && !dv_req; i++) tick();
        check("req_wait", 64'(dv_req), 64'd1);
    endtask

    function automatic longint sat(input longint a, input longint b);
        return (b > a) ? 0 : a - b;
    endfunction

    // One stage of dut from its ignition cycle through coast.
    task automatic run_stage(input int s, input longint burn,
                             input longint flow, input longint dry,
                             input int ack_dly, input bit last,
                             inout longint m);
        longint mend;
        int n;
        check("stage", 64'(stage), 64'(s));
        check("m_start", 64'(dv_m_start), 64'(m));
        n = 0;
        while (burning && n < 1000) begin
            n++;
            tick();
        end
        check("burn_len", 64'(n), 64'(burn));
        mend = sat(m, burn * flow);
        check("dv_req", 64'(dv_req), 64'd1);
        check("m_end", 64'(dv_m_end), 64'(mend));
        for (int k = 0; k < ack_dly; k++) begin
            tick();
            check("req_hold", 64'(dv_req), 64'd1);
            check("start_hold", 64'(dv_m_start), 64'(m));
            check("end_hold", 64'(dv_m_end), 64'(mend));
        end
        dv_ack = 1'b1;
        tick();
        dv_ack = 1'b0;
        check("sep_pulse", 64'(sep_pulse), 64'd1);
        check("req_drop", 64'(dv_req), 64'd0);
        tick();
        m = sat(mend, dry);
        check("mass_sep", 64'(mass), 64'(m));
        check("sep_once", 64'(sep_pulse), 64'd0);
        n = 1;
        while (!burning && !done && !dv_req && n < 100) begin
            tick();
            n++;
        end
        check("coast", 64'(n - 1), 64'(COAST));
        if (last) check("done", 64'(done), 64'd1);
    endtask

    initial begin
        longint m;
        int n;
        reset = 1'b0; cfg_we = 1'b0; cfg_stage = '0; cfg_burn = '0;
        cfg_flow = '0; cfg_dry = '0; launch = 1'b0; m0 = '0;
        abort = 1'b0; dv_ack = 1'b0;

        do_reset();
        check("rst_mass", 64'(mass), 64'd0);
        check("rst_stage", 64'(stage), 64'd0);
        check("rst_burn", 64'(burning), 64'd0);
        check("rst_req", 64'(dv_req), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_mstart", 64'(dv_m_start), 64'd0);

        // Single-stage vehicle on the 1-stage instance, immediate ack
        cfg(0, 168, 12363, 137000);
        fire(2965000);
        for (int i = 0; i < 400 && !d1_req; i++) tick();
        check("t1_req", 64'(d1_req), 64'd1);
        check("t1_mstart", 64'(d1_m_start), 64'd2965000);
        check("t1_mend", 64'(d1_m_end), 64'd888016);
        dv_ack = 1'b1;
        tick();
        dv_ack = 1'b0;
        check("t1_sep", 64'(d1_sep), 64'd1);
        tick();
        check("t1_mass", 64'(d1_mass), 64'd751016);
        repeat (COAST) tick();
        check("t1_done", 64'(d1_done), 64'd1);

        // Three stages, ack delayed 5 cycles
        do_reset();
        cfg(0, 5, 10, 100);
        cfg(1, 4, 20, 50);
        cfg(2, 3, 5, 20);
        fire(10000);
        m = 10000;
        run_stage(0, 5, 10, 100, 5, 1'b0, m);
        run_stage(1, 4, 20, 50, 5, 1'b0, m);
        run_stage(2, 3, 5, 20, 5, 1'b1, m);
        check("t2_mass", 64'(mass), 64'd9685);

        // Zero-length burn on stage 1
        do_reset();
        cfg(0, 3, 10, 100);
        cfg(1, 0, 999, 50);
        cfg(2, 4, 7, 20);
        fire(5000);
        m = 5000;
        run_stage(0, 3, 10, 100, 0, 1'b0, m);
        run_stage(1, 0, 999, 50, 0, 1'b0, m);
        run_stage(2, 4, 7, 20, 0, 1'b1, m);
        check("t3_mass", 64'(mass), 64'd4772);

        // Underflow saturates and latches fault, sequence continues
        do_reset();
        cfg(0, 20, 100, 10);
        cfg(1, 2, 5, 0);
        cfg(2, 2, 5, 0);
        fire(1000);
        repeat (10) tick();
        check("t4_zero", 64'(mass), 64'd0);
        check("t4_nofault", 64'(fault), 64'd0);
        tick();
        check("t4_stay0", 64'(mass), 64'd0);
        check("t4_fault", 64'(fault), 64'd1);
        check("t4_burning", 64'(burning), 64'd1);
        for (int i = 0; i < 500 && !done; i++) begin
            dv_ack = dv_req;
            tick();
        end
        dv_ack = 1'b0;
        check("t4_done", 64'(done), 64'd1);
        check("t4_mass", 64'(mass), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_keep", 64'(fault), 64'd1);
        check("t4_idle", 64'(done), 64'd0);

        // Abort together with launch at burn tick 50
        do_reset();
        cfg(0, 100, 1, 5);
        fire(5000);
        repeat (50) tick();
        check("t5_mid", 64'(mass), 64'd4950);
        abort = 1'b1;
        launch = 1'b1;
        tick();
        abort = 1'b0;
        launch = 1'b0;
        check("t5_burn", 64'(burning), 64'd0);
        check("t5_mass", 64'(mass), 64'd0);
        check("t5_req", 64'(dv_req), 64'd0);
        check("t5_stage", 64'(stage), 64'd0);
        repeat (3) tick();
        check("t5_idle", 64'(burning), 64'd0);
        fire(3000);
        check("t5_relaunch", 64'(burning), 64'd1);
        check("t5_rmass", 64'(mass), 64'd3000);
        check("t5_rstart", 64'(dv_m_start), 64'd3000);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort beats a simultaneous ack
        cfg(0, 2, 1, 5);
        fire(100);
        wait_req();
        dv_ack = 1'b1;
        abort = 1'b1;
        tick();
        dv_ack = 1'b0;
        abort = 1'b0;
        check("ab_sep", 64'(sep_pulse), 64'd0);
        check("ab_req", 64'(dv_req), 64'd0);
        tick();
        check("ab_sep2", 64'(sep_pulse), 64'd0);
        check("ab_mass", 64'(mass), 64'd0);

`ifdef LES_JETTISON_EN
        do_reset();
        cfg(0, 1, 1, 0);
        cfg(1, 40, 1000, 0);
        cfg(2, 1, 1, 0);
        fire(1000000);
        wait_req();
        dv_ack = 1'b1;
        tick();
        dv_ack = 1'b0;
        for (int i = 0; i < 20 && !burning; i++) tick();
        check("les_stage", 64'(stage), 64'd1);
        check("les_m0", 64'(mass), 64'd999999);
        repeat (30) tick();
        check("les_pulse", 64'(les_pulse), 64'd1);
        check("les_pre", 64'(mass), 64'd969999);
        tick();
        check("les_dec", 64'(mass), 64'd965370);
        check("les_once", 64'(les_pulse), 64'd0);
        n = 0;
        for (int i = 0; i < 100 && burning; i++) begin
            tick();
            n += int'(les_pulse);
        end
        check("les_count", 64'(n), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
